// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer.
//   fetch_state_e : REQ (issue request), WAIT (request outstanding),
//                   HOLD (instruction presented to decode)
//   ADDR_W / INSTR_W / INSTR_BYTES : address width, instruction width, pc step
//   align_addr()  : forces a redirect target onto an instruction boundary
package fetch_pkg;
  localparam int ADDR_W      = 32;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter: saturating event counter with synchronous clear.
//   clk     : clock
//   i_clr   : synchronous clear (wins over i_inc)
//   i_inc   : count one event this cycle
//   o_count : current count, sticks at all-ones
module fetch_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch sequencer.
//   clk, rst                        : clock, synchronous active-high reset
//   branch_taken, branch_target     : redirect from execute (highest priority)
//   stall                           : freezes request issue and handoff
//   mem_req_valid/ready/addr        : instruction memory request
//   mem_rsp_valid/data              : one response per accepted request
//   pc                              : current fetch pc (== mem_req_addr)
//   instruction/instr_pc/instr_valid/instr_ready : handoff to decode
//   dbg_state                       : current FSM state (fetch_state_e encoding)
// Optional build macro FETCH_SEQ_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the mem request is only valid in REQ, the instruction only in HOLD,
// and neither payload changes while its valid is high and not yet accepted
// (except on branch_taken, which flushes).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic [1:0]         dbg_state
);
  fetch_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_nxt;
  logic               r_instr_valid, w_instr_valid_nxt;
  // Set when the outstanding request belongs to a flushed path.
  logic               r_discard, w_discard_nxt;
  logic               w_req_valid;
  logic               w_handshake;

  assign w_req_valid = (r_state == ST_REQ) && !stall && !rst;
  assign w_handshake = w_req_valid && mem_req_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_discard_nxt     = r_discard;
    if (branch_taken) begin
      w_pc_nxt          = align_addr(branch_target);
      w_instr_valid_nxt = 1'b0;
      case (r_state)
        ST_REQ: begin
          // The request still goes out; its response must be thrown away.
          if (w_handshake) begin
            w_state_nxt   = ST_WAIT;
            w_discard_nxt = 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            w_state_nxt   = ST_REQ;
            w_discard_nxt = 1'b0;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_handshake) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            if (r_discard) begin
              w_state_nxt   = ST_REQ;
              w_discard_nxt = 1'b0;
            end else begin
              w_instr_nxt       = mem_rsp_data;
              w_instr_pc_nxt    = r_pc;
              w_instr_valid_nxt = 1'b1;
              w_pc_nxt          = r_pc + ADDR_W'(INSTR_BYTES);
              w_state_nxt       = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready && !stall) begin
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = ST_REQ;
          end
        end
        default: w_state_nxt = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = r_pc;
  assign pc            = r_pc;
  assign instruction   = r_instr;
  assign instr_pc      = r_instr_pc;
  assign instr_valid   = r_instr_valid;
  assign dbg_state     = r_state;

`ifdef FETCH_SEQ_PERF_EN
  logic w_flush_evt;
  assign w_flush_evt = branch_taken && !rst;

  fetch_perf_counter #(.W(32)) u_perf_fetch (
    .clk     (clk),
    .i_clr   (rst),
    .i_inc   (w_handshake),
    .o_count (perf_fetch_cnt)
  );

  fetch_perf_counter #(.W(32)) u_perf_flush (
    .clk     (clk),
    .i_clr   (rst),
    .i_inc   (w_flush_evt),
    .o_count (perf_flush_cnt)
  );
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed, table-driven bench for fetch_sequencer.
// Instance dut uses RESET_PC=0; instance dut_w uses RESET_PC=32'hFFFF_FFFC.
// Perf counter checks are compiled only with FETCH_SEQ_PERF_EN.
module tb_fetch_sequencer;
  localparam logic [31:0] I0 = 32'hC0DE_0000, I1 = 32'hC0DE_0004;
  localparam logic [31:0] I2 = 32'hC0DE_0008, I3 = 32'hC0DE_000C;
  localparam logic [31:0] IB = 32'hB0B0_0100, IC = 32'hCCCC_0200;
  localparam logic [31:0] ID = 32'hDDDD_0404, JK = 32'hDEAD_BEEF;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  // ---------------- clock / reset / DUT signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, branch_taken, stall, mem_req_ready, mem_rsp_valid, instr_ready;
  logic [31:0] branch_target, mem_rsp_data;
  logic mem_req_valid, instr_valid;
  logic [31:0] mem_req_addr, pc, instruction, instr_pc;
  logic [1:0] dbg_state;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  logic b_rst, b_rdy, b_rv, b_ir;
  logic [31:0] b_rd;
  logic b_req_valid, b_iv;
  logic [31:0] b_addr, b_pc, b_instr, b_ipc;
  logic [1:0] b_dbg;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .pc(pc), .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
`ifdef FETCH_SEQ_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .dbg_state(dbg_state)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(b_rst), .branch_taken(1'b0), .branch_target(32'h0),
    .stall(1'b0), .mem_req_valid(b_req_valid), .mem_req_ready(b_rdy),
    .mem_req_addr(b_addr), .mem_rsp_valid(b_rv), .mem_rsp_data(b_rd),
    .pc(b_pc), .instruction(b_instr), .instr_pc(b_ipc), .instr_valid(b_iv),
    .instr_ready(b_ir),
`ifdef FETCH_SEQ_PERF_EN
    .perf_fetch_cnt(), .perf_flush_cnt(),
`endif
    .dbg_state(b_dbg)
  );

  // ---------------- monitor: instructions accepted by decode ----------------
  always @(posedge clk) begin
    if (mon_en && !rst && instr_valid && instr_ready && !stall && !branch_taken)
      got_q.push_back(instruction);
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int st, input int br, input logic [31:0] tgt, input int rdy,
                     input int rv, input logic [31:0] rd, input int ir, input int e_req,
                     input logic [31:0] e_addr, input int e_iv, input logic [31:0] e_instr,
                     input logic [31:0] e_ipc);
    vec_t v;
    v.st = (st != 0); v.br = (br != 0); v.tgt = tgt; v.rdy = (rdy != 0);
    v.rv = (rv != 0); v.rd = rd; v.ir = (ir != 0); v.e_req = (e_req != 0);
    v.e_addr = e_addr; v.e_iv = (e_iv != 0); v.e_instr = e_instr; v.e_ipc = e_ipc;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] tgt, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic ir);
    stall = st; branch_taken = br; branch_target = tgt; mem_req_ready = rdy;
    mem_rsp_valid = rv; mem_rsp_data = rd; instr_ready = ir;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1; b_rdy = 1'b0; b_rv = 1'b0; b_rd = 32'h0; b_ir = 1'b0;
    idle();

    // Vector table: {stall, br, tgt, rdy, rsp_v, rsp_d, ir | req_v, addr, iv, instr, ipc}
    // three back-to-back fetches from pc 0
    add(0,0,0,1,0,0,1,   1,32'h0,0,0,0);
    add(0,0,0,1,1,I0,1,  0,32'h0,0,0,0);
    add(0,0,0,1,0,0,1,   0,32'h4,1,I0,32'h0);
    add(0,0,0,1,0,0,1,   1,32'h4,0,I0,32'h0);
    add(0,0,0,1,1,I1,1,  0,32'h4,0,I0,32'h0);
    add(0,0,0,1,0,0,1,   0,32'h8,1,I1,32'h4);
    add(0,0,0,1,0,0,1,   1,32'h8,0,I1,32'h4);
    add(0,0,0,1,1,I2,1,  0,32'h8,0,I1,32'h4);
    add(0,0,0,1,0,0,1,   0,32'hC,1,I2,32'h8);
    // stall during capture, then held 5 cycles in HOLD
    add(0,0,0,1,0,0,1,   1,32'hC,0,I2,32'h8);
    add(1,0,0,1,1,I3,1,  0,32'hC,0,I2,32'h8);
    for (int k = 0; k < 5; k++) add(1,0,0,1,0,0,1, 0,32'h10,1,I3,32'hC);
    add(0,0,0,1,0,0,1,   0,32'h10,1,I3,32'hC);
    add(1,0,0,1,0,0,1,   0,32'h10,0,I3,32'hC);
    add(0,0,0,0,0,0,1,   1,32'h10,0,I3,32'hC);
    // branch in WAIT to unaligned target, late response dropped
    add(0,0,0,1,0,0,1,   1,32'h10,0,I3,32'hC);
    add(0,1,32'h103,0,0,0,1, 0,32'h10,0,I3,32'hC);
    add(0,0,0,0,1,JK,1,  0,32'h100,0,I3,32'hC);
    add(0,0,0,1,0,0,1,   1,32'h100,0,I3,32'hC);
    add(0,0,0,1,1,IB,1,  0,32'h100,0,I3,32'hC);
    add(0,0,0,1,0,0,1,   0,32'h104,1,IB,32'h100);
    // branch coincident with REQ handshake
    add(0,1,32'h200,1,0,0,1, 1,32'h104,0,IB,32'h100);
    add(0,0,0,0,1,JK,1,  0,32'h200,0,IB,32'h100);
    add(0,0,0,1,0,0,1,   1,32'h200,0,IB,32'h100);
    add(0,0,0,1,1,IC,0,  0,32'h200,0,IB,32'h100);
    add(0,0,0,0,0,0,0,   0,32'h204,1,IC,32'h200);
    // branch in HOLD drops the held instruction
    add(0,1,32'h300,0,0,0,0, 0,32'h204,1,IC,32'h200);
    add(0,0,0,1,0,0,1,   1,32'h300,0,IC,32'h200);
    // branch with response in the same WAIT cycle
    add(0,1,32'h404,0,1,JK,1, 0,32'h300,0,IC,32'h200);
    add(0,0,0,1,1,JK,1,  1,32'h404,0,IC,32'h200);
    add(0,0,0,1,1,ID,1,  0,32'h404,0,IC,32'h200);
    add(0,0,0,1,1,JK,1,  0,32'h408,1,ID,32'h404);
    // branch in REQ without handshake, then request uses the new pc
    add(0,1,32'h50,0,0,0,1, 1,32'h408,0,ID,32'h404);
    add(0,0,0,1,0,0,1,   1,32'h50,0,ID,32'h404);

    exp_q.push_back(I0); exp_q.push_back(I1); exp_q.push_back(I2);
    exp_q.push_back(I3); exp_q.push_back(IB); exp_q.push_back(ID);

    // reset: two edges with rst high, request must stay low
    @(negedge clk);
    #1 chk("rst req_valid", {31'b0, mem_req_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst pc", pc, 32'h0);
    chk("rst instruction", instruction, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst state", {30'b0, dbg_state}, 32'h0);
    mon_en = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].st, vq[i].br, vq[i].tgt, vq[i].rdy, vq[i].rv, vq[i].rd, vq[i].ir);
      #1;
      chk($sformatf("v%0d req_valid", i), {31'b0, mem_req_valid}, {31'b0, vq[i].e_req});
      chk($sformatf("v%0d req_addr", i), mem_req_addr, vq[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vq[i].e_iv});
      chk($sformatf("v%0d instruction", i), instruction, vq[i].e_instr);
      chk($sformatf("v%0d instr_pc", i), instr_pc, vq[i].e_ipc);
      @(negedge clk);
    end

    // reset while WAIT is outstanding; the late response must be ignored
    chk("pre-rst state wait", {30'b0, dbg_state}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1 chk("rst-wait req_valid", {31'b0, mem_req_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0077, 1'b1);
    #1;
    chk("rst-wait state", {30'b0, dbg_state}, 32'h0);
    chk("rst-wait pc", pc, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("late rsp state", {30'b0, dbg_state}, 32'h0);
    chk("late rsp instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("late rsp instruction", instruction, 32'h0);
    mon_en = 1'b0;

    // scoreboard: instructions accepted by decode, in order
    chk("sb count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("sb instr", got_q.pop_front(), exp_q.pop_front());

    // pc wrap with RESET_PC = 0xFFFF_FFFC
    @(negedge clk);
    b_rst = 1'b0; b_rdy = 1'b1;
    #1;
    chk("wrap req_valid", {31'b0, b_req_valid}, 32'h1);
    chk("wrap first addr", b_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    b_rv = 1'b1; b_rd = 32'h1234_5678;
    @(negedge clk);
    b_rv = 1'b0; b_ir = 1'b1;
    #1;
    chk("wrap instr_valid", {31'b0, b_iv}, 32'h1);
    chk("wrap instr_pc", b_ipc, 32'hFFFF_FFFC);
    chk("wrap instruction", b_instr, 32'h1234_5678);
    @(negedge clk);
    #1;
    chk("wrap next req", {31'b0, b_req_valid}, 32'h1);
    chk("wrap next addr", b_addr, 32'h0000_0000);

`ifdef FETCH_SEQ_PERF_EN
    // preload near saturation, then 3 fetches and 2 branch cycles
    @(negedge clk);
    idle();
    force dut.u_perf_fetch.r_count = 32'hFFFF_FFFD;
    force dut.u_perf_flush.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_perf_fetch.r_count;
    release dut.u_perf_flush.r_count;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
      @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    end
    for (int f = 0; f < 2; f++) begin
      @(negedge clk); drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    @(negedge clk);
    idle();
    #1;
    chk("perf fetch sat", perf_fetch_cnt, 32'hFFFF_FFFF);
    chk("perf flush sat", perf_flush_cnt, 32'hFFFF_FFFF);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("perf fetch clr", perf_fetch_cnt, 32'h0);
    chk("perf flush clr", perf_flush_cnt, 32'h0);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 branch_taken  input  1  redirect request from execute.
REQ-005 branch_target  input  32  redirect address.
REQ-006 stall  input  1  freezes request issue and instruction handoff.
REQ-007 mem_req_valid  output  1  instruction-memory request valid.
REQ-008 mem_req_ready  input  1  memory accepts the request.
REQ-009 mem_req_addr  output  32  request address, always equal to pc.
REQ-010 mem_rsp_valid  input  1  read data valid, one pulse per accepted request.
REQ-011 mem_rsp_data  input  32  read data.
REQ-012 pc  output  32  current fetch PC.
REQ-013 instruction  output  32  fetched instruction, registered.
REQ-014 instr_pc  output  32  address of instruction, registered.
REQ-015 instr_valid  output  1  instruction and instr_pc are valid.
REQ-016 instr_ready  input  1  decode accepts instruction.

Function
REQ-017 The FSM SHALL have states REQ, WAIT and HOLD, with at most one memory request outstanding.
REQ-018 In REQ, mem_req_valid SHALL equal !stall; mem_req_valid && mem_req_ready SHALL move the FSM to WAIT.
REQ-019 In WAIT, mem_rsp_valid SHALL load instruction and instr_pc, set instr_valid, advance pc by 4, and move the FSM to HOLD; stall SHALL NOT block this capture.
REQ-020 In HOLD, instr_ready && !stall SHALL clear instr_valid and return the FSM to REQ; otherwise instruction and instr_valid SHALL stay stable.
REQ-021 A request SHALL be issued no earlier than the cycle after a HOLD handoff; minimum period is 3 cycles per instruction.
REQ-022 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-023 branch_taken SHALL take priority over stall and every other event in all states.
REQ-024 On branch_taken, pc SHALL load {branch_target[31:2],2'b00} and instr_valid SHALL clear on the next edge.
REQ-025 branch_taken in REQ without a handshake SHALL keep the FSM in REQ; the next request SHALL use the new pc.
REQ-026 branch_taken coincident with a REQ handshake SHALL move the FSM to WAIT with discard set.
REQ-027 branch_taken in WAIT without mem_rsp_valid SHALL set discard and keep the FSM in WAIT.
REQ-028 branch_taken in WAIT with mem_rsp_valid in the same cycle SHALL drop the response and move the FSM to REQ.
REQ-029 branch_taken in HOLD SHALL drop the held instruction and move the FSM to REQ.
REQ-030 A response arriving in WAIT with discard set SHALL be dropped; the FSM SHALL return to REQ with discard cleared and pc unchanged.
REQ-031 mem_rsp_valid in REQ or HOLD SHALL be ignored.

Reset
REQ-032 rst SHALL set state=REQ, pc=RESET_PC, instruction=0, instr_pc=0, instr_valid=0 and discard=0; mem_req_valid SHALL be 0 while rst is high.
REQ-033 rst asserted in WAIT SHALL abandon the outstanding request; its late response SHALL be ignored.

Configuration
REQ-034 With FETCH_SEQ_PERF_EN defined, the block SHALL add outputs perf_fetch_cnt[31:0] and perf_flush_cnt[31:0].
REQ-035 perf_fetch_cnt SHALL count REQ handshakes; perf_flush_cnt SHALL count branch_taken cycles while rst is low.
REQ-036 Both counters SHALL saturate at 32'hFFFF_FFFF and clear on rst.
REQ-037 Without FETCH_SEQ_PERF_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-038 Package fetch_pkg SHALL hold the FSM state enum, ADDR_W=32, INSTR_W=32 and INSTR_BYTES=4.
REQ-039 Sub-module fetch_perf_counter (saturating, synchronous clear) SHALL be instantiated twice, only under FETCH_SEQ_PERF_EN.

Verification
REQ-040 Reset then ready always high, rsp one cycle after request -> addresses 0x0, 0x4, 0x8 issued; instr_pc matches each address.
REQ-041 branch_taken with target 0x103 while in WAIT, then rsp arrives -> rsp dropped, next mem_req_addr=0x100, no instr_valid for the old fetch.
REQ-042 branch_taken in the same cycle as a REQ handshake -> next rsp discarded, next request addr=branch target.
REQ-043 stall held 5 cycles in HOLD with instr_ready=1 -> instruction stable and instr_valid=1 all 5 cycles; handoff on the cycle stall drops.
REQ-044 RESET_PC=32'hFFFF_FFFC, one fetch -> next mem_req_addr=32'h0000_0000.
REQ-045 FETCH_SEQ_PERF_EN, counters preloaded near 32'hFFFF_FFFF, 3 fetches and 2 branches -> both counters hold 32'hFFFF_FFFF; rst -> both counters 0.
